pwm_fade_ctrl: RTL

//  Sequencer that drives the 4-bit duty input of a 16-clock-frame PWM generator to produce
//  a triangular "breathing" fade: ramp up, hold high, ramp down, hold low, optional loop.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_frame_timer.sv | 23 ++
 rtl/pwm_fade_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the PWM fade sequencer
package pwm_pkg;

    localparam int DUTY_W    = 4;
    localparam int FRAME_LEN = 16;
    localparam int FRAME_W   = $clog2(FRAME_LEN);
    localparam int STEP_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        HOLD_HI,
        RAMP_DOWN,
        HOLD_LO
    } fade_state_t;

    // Terminal value of the step counter; a request of zero frames behaves as one frame.
    function automatic logic [STEP_W-1:0] step_last(input logic [STEP_W-1:0] frames);
        return (frames == '0) ? '0 : frames - STEP_W'(1);
    endfunction

endpackage

// File: rtl/pwm_frame_timer.sv
// rtl/pwm_frame_timer.sv - free-running PWM frame position and end-of-frame tick
module pwm_frame_timer
    import pwm_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    output logic o_frame_tick
);

    logic [FRAME_W-1:0] r_frame;

    // Frame position wraps naturally at FRAME_LEN so it stays aligned with the PWM generator.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame <= '0;
        end else begin
            r_frame <= r_frame + FRAME_W'(1);
        end
    end

    assign o_frame_tick = (r_frame == FRAME_W'(FRAME_LEN - 1));

endmodule

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - breathing-fade sequencer driving the PWM duty input on frame boundaries
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter logic [DUTY_W-1:0] DUTY_MIN    = 4'h0,
    parameter logic [DUTY_W-1:0] DUTY_MAX    = 4'hF,
    parameter int                HOLD_FRAMES = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop,
    input  logic [STEP_W-1:0] i_step_frames,
    output logic [DUTY_W-1:0] o_w,
    output logic              o_frame_tick,
    output logic              o_busy,
    output logic              o_done
);

    localparam int                HOLD_W    = $clog2(HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    fade_state_t       state;
    fade_state_t       state_n;
    logic [DUTY_W-1:0] w_n;
    logic [DUTY_W-1:0] w_inc;
    logic [DUTY_W-1:0] w_dec;
    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] step_n;
    logic [STEP_W-1:0] step_lim;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] hold_n;
    logic              r_stop_pend;
    logic              stop_pend_n;
    logic              done_n;
    logic              stop_req;
    logic              step_due;

    pwm_frame_timer u_frame_timer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .o_frame_tick (o_frame_tick)
    );

    assign w_inc    = o_w + DUTY_W'(1);
    assign w_dec    = o_w - DUTY_W'(1);
    assign step_lim = step_last(i_step_frames);
    // >= rather than == so a shortened step length mid-ramp cannot strand the counter.
    assign step_due = (r_step >= step_lim);
    assign stop_req = r_stop_pend | i_stop;
    assign o_busy   = (state != IDLE);

    // State, duty, counters and the one-cycle done pulse are all registered here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            o_w         <= DUTY_MIN;
            r_step      <= '0;
            r_hold      <= '0;
            r_stop_pend <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state       <= state_n;
            o_w         <= w_n;
            r_step      <= step_n;
            r_hold      <= hold_n;
            r_stop_pend <= stop_pend_n;
            o_done      <= done_n;
        end
    end

    // Next-state logic: start is taken on any idle cycle, everything else waits for a frame tick.
    always_comb begin
        state_n     = state;
        w_n         = o_w;
        step_n      = r_step;
        hold_n      = r_hold;
        stop_pend_n = r_stop_pend;
        done_n      = 1'b0;

        if (state == IDLE) begin
            stop_pend_n = 1'b0;
            if (i_start && !i_stop) begin
                state_n = RAMP_UP;
                step_n  = '0;
                hold_n  = '0;
                w_n     = DUTY_MIN;
            end
        end else begin
            stop_pend_n = stop_req;
            if (o_frame_tick) begin
                if (stop_req) begin
                    state_n     = IDLE;
                    w_n         = DUTY_MIN;
                    step_n      = '0;
                    hold_n      = '0;
                    stop_pend_n = 1'b0;
                end else begin
                    case (state)
                        RAMP_UP: begin
                            if (step_due) begin
                                step_n = '0;
                                w_n    = w_inc;
                                if (w_inc == DUTY_MAX) begin
                                    state_n = HOLD_HI;
                                    hold_n  = '0;
                                end
                            end else begin
                                step_n = r_step + STEP_W'(1);
                            end
                        end
                        HOLD_HI: begin
                            if (r_hold == HOLD_LAST) begin
                                state_n = RAMP_DOWN;
                                step_n  = '0;
                                hold_n  = '0;
                            end else begin
                                hold_n = r_hold + HOLD_W'(1);
                            end
                        end
                        RAMP_DOWN: begin
                            if (step_due) begin
                                step_n = '0;
                                w_n    = w_dec;
                                if (w_dec == DUTY_MIN) begin
                                    state_n = HOLD_LO;
                                    hold_n  = '0;
                                end
                            end else begin
                                step_n = r_step + STEP_W'(1);
                            end
                        end
                        HOLD_LO: begin
                            if (r_hold == HOLD_LAST) begin
                                hold_n = '0;
                                step_n = '0;
                                if (i_loop) begin
                                    state_n = RAMP_UP;
                                end else begin
                                    state_n = IDLE;
                                    done_n  = 1'b1;
                                end
                            end else begin
                                hold_n = r_hold + HOLD_W'(1);
                            end
                        end
                        default: begin
                            state_n = IDLE;
                            w_n     = DUTY_MIN;
                        end
                    endcase
                end
            end
        end
    end

endmodule
